// File: rtl/feature_unloader_pkg.sv
// Shared types and helpers for the feature unloader slice.
// FEATURE_UNLOADER_ZPAD_EN (optional) selects zero padding of out-of-window lanes.
package feature_unloader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic int unsigned calc_epw(input int unsigned out_w, input int unsigned elem_w);
        return out_w / elem_w;
    endfunction

endpackage

// File: rtl/feature_unloader_if.sv
// Output word stream of the feature unloader (valid/ready with last marker).
interface feature_unloader_if #(
    parameter int unsigned outputWidth = 256
) ();

    logic [outputWidth-1:0] data_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   last_o;

    modport master (
        output data_o,
        output valid_o,
        output last_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        input  last_o,
        output ready_i
    );

endinterface

// File: rtl/unloader_lane_mux.sv
// Combinational lane selector: builds output word k of a drain from the snapshot.
// FEATURE_UNLOADER_ZPAD_EN zeroes lanes past the window or the buffer end.
module unloader_lane_mux
    import feature_unloader_pkg::*;
#(
    parameter int unsigned outputWidth  = 256,
    parameter int unsigned addrWidth    = 8,
    parameter int unsigned elementWidth = 8,
    parameter int unsigned numElements  = 128,
    parameter int unsigned kWidth       = 9
) (
    input  logic [numElements-1:0][elementWidth-1:0] snap,
    input  logic [addrWidth-1:0]                     base,
    input  logic [addrWidth-1:0]                     len,
    input  logic [kWidth-1:0]                        k,
    output logic [outputWidth-1:0]                   word,
    output logic                                     last_word
);

    localparam int unsigned EPW  = calc_epw(outputWidth, elementWidth);
    localparam int unsigned NE   = numElements;
    localparam int unsigned SELW = (numElements > 1) ? $clog2(numElements) : 1;

    // Index math is done in 32 bits so base + k*EPW + i never wraps before the range check.
    always_comb begin
        int unsigned             e;
        logic [SELW-1:0]         sel;
        logic [elementWidth-1:0] lane;
`ifdef FEATURE_UNLOADER_ZPAD_EN
        logic                    pad;
        pad  = 1'b0;
`endif
        e    = '0;
        sel  = '0;
        lane = '0;
        word = '0;
        for (int unsigned i = 0; i < EPW; i++) begin
            e   = 32'(base) + 32'(k) * EPW + i;
            sel = SELW'(e % NE);
`ifdef FEATURE_UNLOADER_ZPAD_EN
            pad  = (e >= 32'(base) + 32'(len)) || (e >= NE);
            lane = pad ? '0 : snap[sel];
`else
            lane = snap[sel];
`endif
            word[(EPW-1-i)*elementWidth +: elementWidth] = lane;
        end
    end

    always_comb begin
        int unsigned nwords;
        nwords    = (32'(len) + EPW - 1) / EPW;
        last_word = (32'(k) + 1 == nwords);
    end

endmodule

// File: rtl/feature_unloader.sv
// Snapshots a parallel element vector and drains a [base, base+len) window as packed words.
// Optional macro FEATURE_UNLOADER_ZPAD_EN: zero-pad lanes outside the window.
module feature_unloader
    import feature_unloader_pkg::*;
#(
    parameter int unsigned outputWidth  = 256,
    parameter int unsigned addrWidth    = 8,
    parameter int unsigned elementWidth = 8,
    parameter int unsigned numElements  = 128
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic [numElements-1:0][elementWidth-1:0] data_i,
    input  logic                                     load_i,
    input  logic [addrWidth-1:0]                     base_i,
    input  logic [addrWidth-1:0]                     len_i,
    feature_unloader_if.master                       stream,
    output logic                                     busy_o,
    output logic                                     done_o
);

    localparam int unsigned KW = addrWidth + 1;

    state_t                                   state_q, state_d;
    logic [KW-1:0]                            k_q;
    logic [numElements-1:0][elementWidth-1:0] snap_q;
    logic [addrWidth-1:0]                     base_q;
    logic [addrWidth-1:0]                     len_q;
    logic [outputWidth-1:0]                   word;
    logic                                     last_word;
    logic                                     fire;
    logic                                     start;

    unloader_lane_mux #(
        .outputWidth  (outputWidth),
        .addrWidth    (addrWidth),
        .elementWidth (elementWidth),
        .numElements  (numElements),
        .kWidth       (KW)
    ) u_lane_mux (
        .snap      (snap_q),
        .base      (base_q),
        .len       (len_q),
        .k         (k_q),
        .word      (word),
        .last_word (last_word)
    );

    assign start = (state_q == ST_IDLE) && load_i;
    assign fire  = (state_q == ST_DRAIN) && stream.ready_i;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load_i) state_d = (len_i == '0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (fire && last_word) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            k_q    <= '0;
            snap_q <= '0;
            base_q <= '0;
            len_q  <= '0;
        end else if (start) begin
            k_q    <= '0;
            snap_q <= data_i;
            base_q <= base_i;
            len_q  <= len_i;
        end else if (fire) begin
            k_q    <= k_q + KW'(1);
        end
    end

    // Word is gated so data_o reads zero whenever no word is being offered.
    assign stream.valid_o = (state_q == ST_DRAIN);
    assign stream.last_o  = (state_q == ST_DRAIN) && last_word;
    assign stream.data_o  = (state_q == ST_DRAIN) ? word : '0;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);

endmodule

// File: tb/tb_feature_unloader.sv
// Scoreboard bench for feature_unloader: expected words are queued at load and checked on handshake.
module tb_feature_unloader;
    import feature_unloader_pkg::*;

    localparam int unsigned OW  = 256;
    localparam int unsigned AW  = 8;
    localparam int unsigned EW  = 8;
    localparam int unsigned NE  = 128;
    localparam int unsigned EPW = OW / EW;
    localparam int unsigned SW  = $clog2(NE);

    logic                   clk = 1'b0;
    logic                   nrst;
    logic [NE-1:0][EW-1:0]  data_i;
    logic                   load_i;
    logic [AW-1:0]          base_i;
    logic [AW-1:0]          len_i;
    logic                   busy_o;
    logic                   done_o;

    feature_unloader_if #(.outputWidth(OW)) stream ();

    feature_unloader #(
        .outputWidth  (OW),
        .addrWidth    (AW),
        .elementWidth (EW),
        .numElements  (NE)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .data_i (data_i),
        .load_i (load_i),
        .base_i (base_i),
        .len_i  (len_i),
        .stream (stream),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            hs_cnt = 0;
    int            done_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    function automatic logic [OW-1:0] model_word(input logic [NE-1:0][EW-1:0] snap,
                                                 input int unsigned b, input int unsigned l,
                                                 input int unsigned k);
        logic [OW-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < EPW; i++) begin
            int unsigned e;
            logic [EW-1:0] v;
            e = b + k * EPW + i;
            if (e < b + l && e < NE) v = snap[SW'(e)];
            else begin
`ifdef FEATURE_UNLOADER_ZPAD_EN
                v = '0;
`else
                v = snap[SW'(e % NE)];
`endif
            end
            w[(EPW-1-i)*EW +: EW] = v;
        end
        return w;
    endfunction

    // Monitor: stall stability and scoreboard pop on every handshake.
    always @(negedge clk) begin
        exp_t x;
        if (!nrst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (stream.valid_o !== 1'b1 || stream.data_o !== prev_data || stream.last_o !== prev_last) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%b last=%b data=%h required valid=1 last=%b data=%h",
                             stream.valid_o, stream.last_o, stream.data_o, prev_last, prev_data);
                end
            end
            if (stream.valid_o === 1'b1 && stream.ready_i === 1'b1) begin
                hs_cnt++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: data=%h last=%b required no word", stream.data_o, stream.last_o);
                end else begin
                    x = sb.pop_front();
                    if (stream.data_o !== x.data || stream.last_o !== x.last) begin
                        bad++;
                        $display("FAIL word: data=%h last=%b required data=%h last=%b",
                                 stream.data_o, stream.last_o, x.data, x.last);
                    end
                end
            end
            if (done_o === 1'b1) done_cnt++;
            prev_stall = (stream.valid_o === 1'b1) && (stream.ready_i === 1'b0);
            prev_data  = stream.data_o;
            prev_last  = stream.last_o;
        end
    end

    task automatic fill_data();
        for (int j = 0; j < int'(NE); j++) data_i[j] = EW'(j);
    endtask

    task automatic start_drain(input int unsigned b, input int unsigned l);
        int unsigned nw;
        exp_t x;
        nw = (l + EPW - 1) / EPW;
        @(posedge clk); #1;
        hs_cnt   = 0;
        done_cnt = 0;
        base_i   = AW'(b);
        len_i    = AW'(l);
        load_i   = 1'b1;
        for (int unsigned k = 0; k < nw; k++) begin
            x.data = model_word(data_i, b, l, k);
            x.last = (k == nw - 1);
            sb.push_back(x);
        end
        @(posedge clk); #1;
        load_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit toggle, input int exp_cycle);
        bit seen;
        int cyc;
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen = 1'b1;
                cyc  = c;
                break;
            end
            @(posedge clk); #1;
            if (toggle) stream.ready_i = ~stream.ready_i;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout: no done_o within %0d cycles", name, budget);
        end else if (cyc != exp_cycle) begin
            bad++;
            $display("FAIL %s_done_cycle: done at %0d required %0d", name, cyc, exp_cycle);
        end
    endtask

    task automatic finish_check(input string name, input int exp_words);
        @(negedge clk);
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: done=%b busy=%b required 0 0", name, done_o, busy_o);
        end
        total++;
        if (sb.size() != 0 || hs_cnt != exp_words) begin
            bad++;
            $display("FAIL %s_words: got %0d left %0d required %0d left 0", name, hs_cnt, sb.size(), exp_words);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL %s_done_pulses: got %0d required 1", name, done_cnt);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if (stream.data_o !== '0 || stream.valid_o !== 1'b0 || stream.last_o !== 1'b0 ||
            busy_o !== 1'b0 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL %s: data=%h valid=%b last=%b busy=%b done=%b required all 0", name,
                     stream.data_o, stream.valid_o, stream.last_o, busy_o, done_o);
        end
    endtask

    task automatic test_reset();
        nrst           = 1'b0;
        load_i         = 1'b0;
        base_i         = '0;
        len_i          = '0;
        stream.ready_i = 1'b1;
        fill_data();
        #3;
        check_all_zero("reset_outputs");
        @(posedge clk); #1;
        nrst = 1'b1;
    endtask

    task automatic test_basic();
        stream.ready_i = 1'b1;
        fill_data();
        start_drain(0, 64);
        @(negedge clk);
        total++;
        if (stream.valid_o !== 1'b1 || stream.last_o !== 1'b0 ||
            stream.data_o[OW-1 -: EW] !== 8'h00 || stream.data_o[EW-1:0] !== 8'h1F) begin
            bad++;
            $display("FAIL basic_word0: valid=%b last=%b msb=%h lsb=%h required 1 0 00 1f",
                     stream.valid_o, stream.last_o, stream.data_o[OW-1 -: EW], stream.data_o[EW-1:0]);
        end
        @(negedge clk);
        total++;
        if (stream.valid_o !== 1'b1 || stream.last_o !== 1'b1 || stream.data_o[OW-1 -: EW] !== 8'h20) begin
            bad++;
            $display("FAIL basic_word1: valid=%b last=%b msb=%h required 1 1 20",
                     stream.valid_o, stream.last_o, stream.data_o[OW-1 -: EW]);
        end
        wait_done("basic", 10, 1'b0, 1);
        finish_check("basic", 2);
    endtask

    task automatic test_window();
        logic [EW-1:0] exp_lane9;
`ifdef FEATURE_UNLOADER_ZPAD_EN
        exp_lane9 = 8'h00;
`else
        exp_lane9 = 8'h01;
`endif
        stream.ready_i = 1'b1;
        fill_data();
        start_drain(120, 16);
        @(negedge clk);
        total++;
        if (stream.last_o !== 1'b1 || stream.data_o[OW-1 -: EW] !== 8'd120 ||
            stream.data_o[(EPW-1-7)*EW +: EW] !== 8'd127 || stream.data_o[(EPW-1-9)*EW +: EW] !== exp_lane9) begin
            bad++;
            $display("FAIL window_lanes: last=%b lane0=%h lane7=%h lane9=%h required 1 78 7f %h",
                     stream.last_o, stream.data_o[OW-1 -: EW], stream.data_o[(EPW-1-7)*EW +: EW],
                     stream.data_o[(EPW-1-9)*EW +: EW], exp_lane9);
        end
        wait_done("window", 10, 1'b0, 1);
        finish_check("window", 1);
    endtask

    task automatic test_stall();
        stream.ready_i = 1'b1;
        fill_data();
        start_drain(0, 33);
        // Output must keep coming from the snapshot, not the live input.
        for (int j = 0; j < int'(NE); j++) data_i[j] = ~EW'(j);
        wait_done("stall", 20, 1'b1, 4);
        finish_check("stall", 2);
    endtask

    task automatic test_len_zero();
        stream.ready_i = 1'b1;
        fill_data();
        start_drain(7, 0);
        wait_done("len0", 10, 1'b0, 1);
        total++;
        if (stream.valid_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL len0_state: valid=%b busy=%b required 0 1", stream.valid_o, busy_o);
        end
        finish_check("len0", 0);
    endtask

    task automatic test_load_ignored();
        stream.ready_i = 1'b0;
        fill_data();
        start_drain(0, 64);
        @(posedge clk); #1;
        base_i = 8'd5;
        len_i  = 8'd3;
        load_i = 1'b1;
        @(posedge clk); #1;
        load_i         = 1'b0;
        stream.ready_i = 1'b1;
        wait_done("load_ign", 20, 1'b0, 3);
        finish_check("load_ign", 2);
    endtask

    task automatic test_reset_mid_drain();
        stream.ready_i = 1'b1;
        fill_data();
        start_drain(0, 128);
        @(posedge clk);
        total++;
        if (hs_cnt != 1) begin
            bad++;
            $display("FAIL rst_first_hs: got %0d handshakes required 1", hs_cnt);
        end
        #1;
        nrst = 1'b0;
        #1;
        check_all_zero("rst_async");
        sb.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (done_o !== 1'b0 || stream.valid_o !== 1'b0) begin
                bad++;
                $display("FAIL rst_hold: done=%b valid=%b required 0 0", done_o, stream.valid_o);
            end
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        start_drain(0, 32);
        wait_done("rst_reload", 10, 1'b0, 2);
        finish_check("rst_reload", 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window();
        test_stall();
        test_len_zero();
        test_load_ignored();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
